touch_region_hold_counter: RTL and testbench

//  Parametrised touch-region hold counter for the LTM touch-panel path. Maps each

---
 rtl/touch_region_hold_counter_if.sv | 35 +++
 rtl/touch_region_hold_counter.sv | 252 +++++++++++++++++++++++++
 tb/tb_touch_region_hold_counter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/touch_region_hold_counter_if.sv
// Touch-region hold counter bus.
// The master side (panel/controller) drives pen-down, coordinates and clear.
// The slave side (counter block) returns the region code, cell counters,
// hold pulse/region, mode result and elapsed-time BCD.
interface touch_region_hold_counter_if #(
  parameter int COORD_W = 12,
  parameter int NREG    = 4,
  parameter int CNT_W   = 3
);
  localparam int REG_W = $clog2(NREG);

  logic                    Touch_En;
  logic [COORD_W-1:0]      Coord_X;
  logic [COORD_W-1:0]      Coord_Y;
  logic                    Clear;
  logic [REG_W-1:0]        Region_Code;
  logic [NREG*CNT_W-1:0]   Count_Vector;
  logic                    Hold_Pulse;
  logic [REG_W-1:0]        Hold_Region;
  logic [CNT_W-1:0]        Mode_Value;
  logic                    Mode_Valid;
  logic [15:0]             Elapsed_BCD;

  modport master (
    output Touch_En, Coord_X, Coord_Y, Clear,
    input  Region_Code, Count_Vector, Hold_Pulse, Hold_Region,
           Mode_Value, Mode_Valid, Elapsed_BCD
  );

  modport slave (
    input  Touch_En, Coord_X, Coord_Y, Clear,
    output Region_Code, Count_Vector, Hold_Pulse, Hold_Region,
           Mode_Value, Mode_Valid, Elapsed_BCD
  );
endinterface

// File: rtl/touch_region_hold_counter.sv
// Touch-region hold counter.
// Maps the touch coordinate to a cell of a GRID_COLS x GRID_ROWS grid; every
// completed hold period in one cell steps that cell's wrap-around counter
// (up or down per DOWN_MASK). A one-cell-per-cycle scanner reports the most
// frequent counter value, and a ms prescaler tracks touch duration in BCD.
// Ports:
//   Clock   - system clock
//   Resetn  - synchronous active-low reset
//   bus     - slave side of touch_region_hold_counter_if (inputs Touch_En,
//             Coord_X/Y, Clear; outputs Region_Code, Count_Vector,
//             Hold_Pulse, Hold_Region, Mode_Value, Mode_Valid, Elapsed_BCD)

// One grid cell: wrap-around counter, stepped by the hold logic.
module touch_cell_counter #(
  parameter int CNT_W = 3,
  parameter bit DOWN  = 1'b0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             clear,
  input  logic             step,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] INIT = {CNT_W{DOWN}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)     cnt_d = INIT;
    else if (step) cnt_d = DOWN ? cnt_q - 1'b1 : cnt_q + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) cnt_q <= INIT;
    else         cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module touch_region_hold_counter #(
  parameter int GRID_COLS   = 2,
  parameter int GRID_ROWS   = 2,
  parameter int COORD_W     = 12,
  parameter int CNT_W       = 3,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int MS_CYCLES   = 50_000,
  parameter logic [GRID_COLS*GRID_ROWS-1:0] DOWN_MASK = 4'b0110
) (
  input  logic Clock,
  input  logic Resetn,
  touch_region_hold_counter_if.slave bus
);
  localparam int NREG  = GRID_COLS * GRID_ROWS;
  localparam int CB    = $clog2(GRID_COLS);
  localparam int RB    = $clog2(GRID_ROWS);
  localparam int REG_W = CB + RB;
  localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PRE_W = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam int FRQ_W = $clog2(NREG + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_st_e;

  // Power-of-two grid: row*GRID_COLS+col is just {row,col}.
  logic [REG_W-1:0] region;
  assign region = {bus.Coord_Y[COORD_W-1 -: RB], bus.Coord_X[COORD_W-1 -: CB]};
  assign bus.Region_Code = region;

  logic unused_coord_lsbs;
  assign unused_coord_lsbs = &{1'b0, bus.Coord_X[COORD_W-CB-1:0], bus.Coord_Y[COORD_W-RB-1:0]};

  // ---------------- hold timer ----------------
  logic [REG_W-1:0] region_q, region_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             pulse_q, pulse_d;
  logic [REG_W-1:0] hreg_q, hreg_d;
  logic             step;
  logic [NREG-1:0]  step_vec;

  always_comb begin
    region_d = region;
    tmr_d    = '0;
    step     = 1'b0;
    // A region change (including on the terminal cycle) fails the compare
    // and simply restarts the timer, so no step is taken.
    if (bus.Touch_En && (region == region_q)) begin
      if (tmr_q == TMR_W'(HOLD_CYCLES - 1)) step  = 1'b1;
      else                                  tmr_d = tmr_q + 1'b1;
    end
    if (bus.Clear) begin
      step  = 1'b0;
      tmr_d = '0;
    end
    pulse_d = step;
    hreg_d  = step ? region_q : hreg_q;
    for (int r = 0; r < NREG; r++) step_vec[r] = step && (region_q == REG_W'(r));
  end

  // ---------------- cell counters ----------------
  logic [NREG*CNT_W-1:0] count_vec;

  for (genvar r = 0; r < NREG; r++) begin : g_cell
    touch_cell_counter #(.CNT_W(CNT_W), .DOWN(DOWN_MASK[r])) u_cell (
      .Clock  (Clock),
      .Resetn (Resetn),
      .clear  (bus.Clear),
      .step   (step_vec[r]),
      .cnt    (count_vec[r*CNT_W +: CNT_W])
    );
  end

  // ---------------- elapsed ms in BCD ----------------
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] o;
    logic        c;
    o = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (v[d*4 +: 4] == 4'd9) o[d*4 +: 4] = 4'd0;
        else begin
          o[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return o;
  endfunction

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [15:0]      bcd_q, bcd_d;

  always_comb begin
    pre_d = '0;
    bcd_d = '0;
    if (bus.Touch_En) begin
      bcd_d = bcd_q;
      if (pre_q == PRE_W'(MS_CYCLES - 1)) begin
        if (bcd_q != 16'h9999) bcd_d = bcd_inc(bcd_q);
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // ---------------- mode scanner ----------------
  scan_st_e              st_q, st_d;
  logic                  dirty_q, dirty_d;
  logic [NREG*CNT_W-1:0] snap_q, snap_d;
  logic [REG_W-1:0]      idx_q, idx_d;
  logic [FRQ_W-1:0]      bfreq_q, bfreq_d;
  logic [CNT_W-1:0]      bval_q, bval_d;
  logic [CNT_W-1:0]      mval_q, mval_d;
  logic                  mvld_q, mvld_d;
  logic [CNT_W-1:0]      cur_val;
  logic [FRQ_W-1:0]      freq;

  // Frequency of the snapshot value under the scan index.
  always_comb begin
    cur_val = snap_q[idx_q*CNT_W +: CNT_W];
    freq    = '0;
    for (int r = 0; r < NREG; r++)
      if (snap_q[r*CNT_W +: CNT_W] == cur_val) freq = freq + FRQ_W'(1);
  end

  always_comb begin
    st_d    = st_q;
    dirty_d = dirty_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    bfreq_d = bfreq_q;
    bval_d  = bval_q;
    mval_d  = mval_q;
    mvld_d  = mvld_q;
    case (st_q)
      S_IDLE: if (dirty_q) begin
        st_d    = S_SCAN;
        snap_d  = count_vec;
        idx_d   = '0;
        dirty_d = 1'b0;
        mvld_d  = 1'b0;
        bfreq_d = '0;
        bval_d  = '0;
      end
      S_SCAN: begin
        if ((freq > bfreq_q) || ((freq == bfreq_q) && (cur_val > bval_q))) begin
          bfreq_d = freq;
          bval_d  = cur_val;
        end
        if (idx_q == REG_W'(NREG - 1)) st_d  = S_DONE;
        else                           idx_d = idx_q + 1'b1;
      end
      S_DONE: begin
        mval_d = bval_q;
        mvld_d = !dirty_q;  // a step during the scan leaves the result stale
        st_d   = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    if (step) begin
      dirty_d = 1'b1;
      mvld_d  = 1'b0;
    end
    if (bus.Clear) begin
      st_d    = S_IDLE;
      dirty_d = 1'b1;
      mvld_d  = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      region_q <= '0;
      tmr_q    <= '0;
      pulse_q  <= 1'b0;
      hreg_q   <= '0;
      pre_q    <= '0;
      bcd_q    <= '0;
      st_q     <= S_IDLE;
      dirty_q  <= 1'b1;
      snap_q   <= '0;
      idx_q    <= '0;
      bfreq_q  <= '0;
      bval_q   <= '0;
      mval_q   <= '0;
      mvld_q   <= 1'b0;
    end else begin
      region_q <= region_d;
      tmr_q    <= tmr_d;
      pulse_q  <= pulse_d;
      hreg_q   <= hreg_d;
      pre_q    <= pre_d;
      bcd_q    <= bcd_d;
      st_q     <= st_d;
      dirty_q  <= dirty_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      bfreq_q  <= bfreq_d;
      bval_q   <= bval_d;
      mval_q   <= mval_d;
      mvld_q   <= mvld_d;
    end
  end

  assign bus.Count_Vector = count_vec;
  assign bus.Hold_Pulse   = pulse_q;
  assign bus.Hold_Region  = hreg_q;
  assign bus.Mode_Value   = mval_q;
  assign bus.Mode_Valid   = mvld_q;
  assign bus.Elapsed_BCD  = bcd_q;
endmodule

// File: tb/tb_touch_region_hold_counter.sv
// Bench for touch_region_hold_counter (2x2 grid, CNT_W=3, HOLD=10, MS=4).
// Expected hold events are queued as stimulus is driven and checked by a
// monitor whenever Hold_Pulse fires; other outputs are checked inline.
module tb_touch_region_hold_counter;
  localparam int HOLD    = 10;
  localparam int MS      = 4;
  localparam int NREG    = 4;
  localparam int CNT_W   = 3;
  localparam int COORD_W = 12;
  localparam logic [3:0] DMASK = 4'b0110;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  touch_region_hold_counter_if #(.COORD_W(COORD_W), .NREG(NREG), .CNT_W(CNT_W)) bus ();

  touch_region_hold_counter #(
    .GRID_COLS(2), .GRID_ROWS(2), .COORD_W(COORD_W), .CNT_W(CNT_W),
    .HOLD_CYCLES(HOLD), .MS_CYCLES(MS), .DOWN_MASK(DMASK)
  ) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [1:0]  region;
    logic [11:0] cv;
  } hold_t;

  hold_t      hq[$];
  logic [2:0] ecnt [4];
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pack_cv();
    return {ecnt[3], ecnt[2], ecnt[1], ecnt[0]};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic exp_reset();
    for (int r = 0; r < 4; r++) ecnt[r] = DMASK[r] ? 3'd7 : 3'd0;
  endtask

  task automatic exp_step(input int r);
    hold_t h;
    if (DMASK[r]) ecnt[r] = ecnt[r] - 3'd1;
    else          ecnt[r] = ecnt[r] + 3'd1;
    h.region = 2'(r);
    h.cv     = pack_cv();
    hq.push_back(h);
  endtask

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_xy(input int x, input int y, input int exp_reg);
    bus.Coord_X = 12'(x);
    bus.Coord_Y = 12'(y);
    #1;
    chk("region_code", 32'(bus.Region_Code), 32'(exp_reg));
  endtask

  // Align region_q with Touch_En low, then hold for n full periods.
  task automatic hold(input int x, input int y, input int n, input int exp_reg);
    bus.Touch_En = 1'b0;
    set_xy(x, y, exp_reg);
    step_cyc();
    bus.Touch_En = 1'b1;
    for (int i = 0; i < n; i++) exp_step(exp_reg);
    repeat (n * HOLD) step_cyc();
    chk("hold_elapsed", 32'(bus.Elapsed_BCD), 32'(to_bcd(n * HOLD / MS)));
    chk("hold_cv", 32'(bus.Count_Vector), 32'(pack_cv()));
    bus.Touch_En = 1'b0;
    step_cyc();
  endtask

  // Scoreboard: every Hold_Pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.Hold_Pulse) begin
      if (hq.size() == 0) chk("unexpected_pulse", 32'(bus.Hold_Region), 32'hdead);
      else begin
        hold_t e;
        e = hq.pop_front();
        chk("pulse_region", 32'(bus.Hold_Region), 32'(e.region));
        chk("pulse_cv", 32'(bus.Count_Vector), 32'(e.cv));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.Touch_En = 1'b0;
    bus.Coord_X  = '0;
    bus.Coord_Y  = '0;
    bus.Clear    = 1'b0;
    exp_reset();

    // 1: reset state and first mode result
    repeat (3) step_cyc();
    chk("rst_cv", 32'(bus.Count_Vector), 32'h1F8);
    chk("rst_pulse", 32'(bus.Hold_Pulse), 0);
    chk("rst_hreg", 32'(bus.Hold_Region), 0);
    chk("rst_mval", 32'(bus.Mode_Value), 0);
    chk("rst_mvld", 32'(bus.Mode_Valid), 0);
    chk("rst_bcd", 32'(bus.Elapsed_BCD), 0);
    rst_n = 1'b1;
    repeat (5) step_cyc();
    chk("t1_mvld_c5", 32'(bus.Mode_Valid), 0);
    step_cyc();
    chk("t1_mvld_c6", 32'(bus.Mode_Valid), 1);
    chk("t1_mval", 32'(bus.Mode_Value), 7);

    // 2: 25 cycles in cell0 -> two steps, 6 ms
    set_xy(100, 100, 0);
    bus.Touch_En = 1'b1;
    exp_step(0);
    exp_step(0);
    for (int c = 1; c <= 25; c++) begin
      step_cyc();
      if (c == 9)  chk("t2_pulse9", 32'(bus.Hold_Pulse), 0);
      if (c == 10) chk("t2_pulse10", 32'(bus.Hold_Pulse), 1);
    end
    chk("t2_bcd", 32'(bus.Elapsed_BCD), 32'h0006);
    chk("t2_cell0", 32'(bus.Count_Vector[2:0]), 2);
    bus.Touch_En = 1'b0;
    step_cyc();
    chk("t2_bcd_rel", 32'(bus.Elapsed_BCD), 0);
    repeat (6) step_cyc();
    chk("t2_mvld", 32'(bus.Mode_Valid), 1);
    chk("t2_mval", 32'(bus.Mode_Value), 7);

    // 3: leave cell1 on its terminal cycle -> no step; cell3 timer restarts
    set_xy(3000, 100, 1);
    step_cyc();
    bus.Touch_En = 1'b1;
    repeat (9) step_cyc();
    chk("t3_pulse_pre", 32'(bus.Hold_Pulse), 0);
    set_xy(3000, 3000, 3);
    step_cyc();
    chk("t3_pulse_abort", 32'(bus.Hold_Pulse), 0);
    chk("t3_cell1", 32'(bus.Count_Vector[5:3]), 7);
    exp_step(3);
    for (int c = 1; c <= 10; c++) begin
      step_cyc();
      if (c == 9)  chk("t3_c3_pulse9", 32'(bus.Hold_Pulse), 0);
      if (c == 10) chk("t3_c3_pulse10", 32'(bus.Hold_Pulse), 1);
    end
    bus.Touch_En = 1'b0;
    step_cyc();

    // 4: wraps; cell0 up 7->0, cell2 down 0->7; mode value changes
    hold(100, 100, 6, 0);
    chk("t4_c0_wrap", 32'(bus.Count_Vector[2:0]), 0);
    hold(100, 3000, 7, 2);
    chk("t4_c2_zero", 32'(bus.Count_Vector[8:6]), 0);
    repeat (6) step_cyc();
    chk("t4_mvld0", 32'(bus.Mode_Valid), 1);
    chk("t4_mval0", 32'(bus.Mode_Value), 0);
    hold(100, 3000, 1, 2);
    chk("t4_c2_wrap", 32'(bus.Count_Vector[8:6]), 7);
    repeat (6) step_cyc();
    chk("t4_mvld7", 32'(bus.Mode_Valid), 1);
    chk("t4_mval7", 32'(bus.Mode_Value), 7);

    // 5: Clear on the terminal hold cycle
    set_xy(3000, 100, 1);
    step_cyc();
    bus.Touch_En = 1'b1;
    repeat (9) step_cyc();
    bus.Clear = 1'b1;
    exp_reset();
    step_cyc();
    chk("t5_pulse", 32'(bus.Hold_Pulse), 0);
    chk("t5_cv", 32'(bus.Count_Vector), 32'(pack_cv()));
    chk("t5_mvld_clr", 32'(bus.Mode_Valid), 0);
    bus.Clear    = 1'b0;
    bus.Touch_En = 1'b0;
    repeat (5) step_cyc();
    chk("t5_mvld_c5", 32'(bus.Mode_Valid), 0);
    step_cyc();
    chk("t5_mvld_c6", 32'(bus.Mode_Valid), 1);
    chk("t5_mval", 32'(bus.Mode_Value), 7);

    // 6: long touch saturates Elapsed_BCD at 9999
    set_xy(100, 100, 0);
    step_cyc();
    bus.Touch_En = 1'b1;
    for (int c = 0; c < 40020; c++) begin
      if (c % HOLD == 0) exp_step(0);
      step_cyc();
      if (c + 1 == 39992) chk("t6_bcd9998", 32'(bus.Elapsed_BCD), 32'h9998);
      if (c + 1 == 39996) chk("t6_bcd9999", 32'(bus.Elapsed_BCD), 32'h9999);
    end
    chk("t6_bcd_sat", 32'(bus.Elapsed_BCD), 32'h9999);
    chk("t6_cv", 32'(bus.Count_Vector), 32'(pack_cv()));
    bus.Touch_En = 1'b0;
    step_cyc();
    chk("t6_bcd_rel", 32'(bus.Elapsed_BCD), 0);

    repeat (4) step_cyc();
    chk("hq_drained", 32'(hq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
